vec_mem_xfer: RTL and testbench
===============================

Name: vec_mem_xfer

Overview:
Vector load/store burst engine that sits directly downstream of the CVP14 control FSM on the VLD/VST path. The core hands over a base address and an opcode. This block then sequences 16 single-element transfers on the 16-bit system memory bus. For a load it assembles a 256-bit vector and delivers it to the vector register file in one write. For a store it serialises a 256-bit vector to memory. It replaces the per-element offset stepping that is currently spread across the core FSM.

Parameters:
LANES, 16, elements per vector (fixed at 16; wider values are not supported).
DW, 16, element and memory data width in bits.
AW, 16, memory address width in bits.
RD_LAT, 1, memory read latency in cycles, legal range 1..4.

Ports:
Clk1  in  1  sole clock; every register updates on posedge Clk1.
Reset  in  1  synchronous, active-high reset.
Start  in  1  one-cycle request pulse, sampled only while idle.
Op  in  1  0 = load (VLD), 1 = store (VST); sampled with Start.
Base  in  AW  base address; sampled with Start.
VecIn  in  LANES*DW  store source vector; sampled with Start.
VecOut  out  LANES*DW  assembled load vector; element i sits at bits [16i+15:16i].
VecWE  out  1  one-cycle strobe that writes VecOut to the vector register file.
Busy  out  1  high from the cycle after Start is accepted until Done.
Done  out  1  one-cycle completion pulse.
MemAddr  out  AW  memory address.
MemRD  out  1  memory read strobe.
MemWR  out  1  memory write strobe.
MemDataOut  out  DW  memory write data.
MemDataIn  in  DW  memory read data.

Behaviour:
- Reset: state IDLE; Busy, Done, VecWE, MemRD, MemWR = 0; MemAddr, MemDataOut, VecOut = 0; index counter = 0; latency pipe cleared.
- All outputs are registered. Call the edge that samples Start "edge 0"; "cycle k" is the cycle following edge k-1.
- States: IDLE, LD_ISSUE, LD_DRAIN, ST_ISSUE, FINISH.
- IDLE: when Start=1, latch Op, Base and VecIn (snapshot), clear the index, and go to LD_ISSUE if Op=0 or ST_ISSUE if Op=1. When Start=0, stay in IDLE.
- Start while Busy=1 is ignored, with no queuing. The snapshot means later changes to VecIn do not affect an in-flight store.
- LD_ISSUE: during cycles 1..16, MemRD=1 and MemAddr=Base+i for i=0..15.
  - Address addition is modulo 2^AW; Base=0xFFFF wraps to 0x0000 for element 1.
  - After i=15, deassert MemRD and go to LD_DRAIN.
- Read capture: MemDataIn for the read issued in cycle k is valid in cycle k+RD_LAT and is sampled at the end of that cycle into VecOut element i.
  - A valid/index shift pipe of depth RD_LAT tracks each outstanding read.
- LD_DRAIN: wait until the last element has been captured, then go to FINISH.
- ST_ISSUE: during cycles 1..16, MemWR=1, MemAddr=Base+i, MemDataOut=snapshot element i. After i=15, go to FINISH.
- FINISH: one cycle with Done=1, then return to IDLE.
  - For a load, VecWE=1 in this same cycle; VecWE is never asserted for a store.
  - Busy goes low in the cycle after FINISH.
- Latency:
  - Store: WR in cycles 1..16, Done in cycle 17.
  - Load: RD in cycles 1..16, last capture at the end of cycle 16+RD_LAT, Done/VecWE in cycle 17+RD_LAT.
- MemRD and MemWR are never high together. MemAddr holds its last value when idle.
- Reset mid-operation aborts the transfer.
  - All strobes drop in the cycle after the reset edge.
  - No Done or VecWE is produced for the aborted transfer.
  - VecOut is cleared.
- Start in the same cycle as Reset is discarded.
- Busy is 1 in every state except IDLE.

Decomposition:
- Shared package cvp14_pkg: OP_LOAD=1'b0 and OP_STORE=1'b1, the vector-unit state encoding, LANES, DW and AW constants, and the opcode constants vld=4'b0100 and vst=4'b0101. The core decodes with the opcode constants before driving Op.
- One sub-module, rd_lat_pipe: a RD_LAT-deep shift register of {valid, index[3:0]} that yields the capture-enable and target element. It is parameterised on RD_LAT, with synchronous reset.

Test Plan:
- Load, RD_LAT=1, Base=0x0100, memory[0x0100+i]=0xA000+i: MemRD high in cycles 1..16 at addresses 0x0100..0x010F; Done=VecWE=1 in cycle 18; VecOut element i = 0xA000+i.
- Store, Base=0x0200, VecIn element i = 0x1111*i (mod 2^16), VecIn changed in cycle 2: 16 writes at 0x0200..0x020F with the original data; Done in cycle 17; VecWE stays 0.
- Wrap: load with Base=0xFFF8 gives addresses 0xFFF8..0xFFFF then 0x0000..0x0007; data lands in elements 0..15 in order.
- RD_LAT=3 load: Done/VecWE in cycle 20; no element is captured before cycle 4; element 15 equals the data returned in cycle 19.
- Start pulsed in cycle 5 of a store: ignored, with exactly 16 writes and one Done; a Start one cycle after Done is accepted.
- Reset asserted in cycle 8 of a load: MemRD=0 and Busy=0 from cycle 9; no Done or VecWE; VecOut=0; a following load completes normally.

Source files
------------

// File: rtl/cvp14_pkg.sv
// cvp14_pkg: constants and types shared by the CVP14 vector memory path.
//   - OP_LOAD / OP_STORE : values carried on the Op line into vec_mem_xfer
//   - vld / vst          : core instruction opcodes for vector load/store
//   - LANES / DW / AW    : vector geometry and memory bus widths
//   - vx_state_e         : vector-unit transfer FSM encoding
//   - rd_tag_t           : {valid, element index} tag for an outstanding read
package cvp14_pkg;

  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int AW    = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [3:0] vld = 4'b0100;
  localparam logic [3:0] vst = 4'b0101;

  typedef enum logic [2:0] {
    VX_IDLE     = 3'd0,
    VX_LD_ISSUE = 3'd1,
    VX_LD_DRAIN = 3'd2,
    VX_ST_ISSUE = 3'd3,
    VX_FINISH   = 3'd4
  } vx_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rd_tag_t;

  // True for the two opcodes that this engine services.
  function automatic logic is_vec_mem_op(input logic [3:0] opcode);
    return (opcode == vld) || (opcode == vst);
  endfunction

  // Maps a decoded vector memory opcode onto the Op line.
  function automatic logic op_from_opcode(input logic [3:0] opcode);
    return (opcode == vst) ? OP_STORE : OP_LOAD;
  endfunction

endpackage

// File: rtl/vec_mem_xfer_if.sv
// vec_mem_xfer_if: single-element system memory bus driven by vec_mem_xfer.
//   MemAddr    : element address
//   MemRD      : read strobe, one element per cycle
//   MemWR      : write strobe, one element per cycle
//   MemDataOut : write data
//   MemDataIn  : read data, valid RD_LAT cycles after the matching MemRD
// master = transfer engine, slave = memory.
interface vec_mem_xfer_if #(
  parameter int AW = cvp14_pkg::AW,
  parameter int DW = cvp14_pkg::DW
);

  logic [AW-1:0] MemAddr;
  logic          MemRD;
  logic          MemWR;
  logic [DW-1:0] MemDataOut;
  logic [DW-1:0] MemDataIn;

  modport master (
    output MemAddr,
    output MemRD,
    output MemWR,
    output MemDataOut,
    input  MemDataIn
  );

  modport slave (
    input  MemAddr,
    input  MemRD,
    input  MemWR,
    input  MemDataOut,
    output MemDataIn
  );

endinterface

// File: rtl/rd_lat_pipe.sv
// rd_lat_pipe: RD_LAT-deep shift register of {valid, index} tags.
//   clk     : clock
//   rst     : synchronous active-high clear of every stage
//   issue   : tag of the read on the bus this cycle
//   capture : tag whose data is on MemDataIn this cycle (capture enable + lane)
// A tag entering at the end of cycle k leaves the last stage during cycle
// k+RD_LAT, which is exactly when the memory returns that read's data.
module rd_lat_pipe
  import cvp14_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t issue,
  output rd_tag_t capture
);

  rd_tag_t stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < RD_LAT; j++) begin
        stage[j] <= '0;
      end
    end else begin
      stage[0] <= issue;
      for (int j = 1; j < RD_LAT; j++) begin
        stage[j] <= stage[j-1];
      end
    end
  end

  assign capture = stage[RD_LAT-1];

endmodule

// File: rtl/vec_mem_xfer.sv
// vec_mem_xfer: VLD/VST burst engine. Sequences LANES single-element
// transfers on the memory bus starting at Base; loads assemble VecOut and
// strobe VecWE once, stores serialise a snapshot of VecIn.
//   Clk1, Reset : clock, synchronous active-high reset
//   Start/Op/Base/VecIn : request, opcode, base address, store source
//   VecOut/VecWE        : assembled load vector and its write strobe
//   Busy/Done           : in-flight flag, one-cycle completion pulse
//   dbg_state           : current FSM state
//   mem                 : memory bus (master side)
//
// Request handshake: Start is a one-cycle request with no ready line. It is
// accepted only on an edge where the engine is idle (Busy=0) and Reset=0;
// any other Start is dropped, never queued. Op, Base and VecIn are captured
// on the accepting edge only.
module vec_mem_xfer
  import cvp14_pkg::*;
#(
  parameter int LANES  = cvp14_pkg::LANES,
  parameter int DW     = cvp14_pkg::DW,
  parameter int AW     = cvp14_pkg::AW,
  parameter int RD_LAT = 1
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Op,
  input  logic [AW-1:0]       Base,
  input  logic [LANES*DW-1:0] VecIn,
  output logic [LANES*DW-1:0] VecOut,
  output logic                VecWE,
  output logic                Busy,
  output logic                Done,
  output vx_state_e           dbg_state,
  vec_mem_xfer_if.master      mem
);

  localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

  vx_state_e state, state_n;

  // Registered datapath and outputs (_q) with their next values (_d).
  logic [3:0]          idx_q, idx_d;
  logic [AW-1:0]       base_q, base_d;
  logic [LANES*DW-1:0] snap_q, snap_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [LANES*DW-1:0] vec_q;

  rd_tag_t issue_tag, cap_tag;

  logic          last_issue;
  logic          last_capture;
  logic [3:0]    idx_inc;
  logic [AW-1:0] addr_inc;

  assign last_issue   = (idx_q == LAST_IDX);
  assign last_capture = cap_tag.valid && (cap_tag.idx == LAST_IDX);
  assign idx_inc      = idx_q + 4'd1;
  // Base + i wraps modulo 2^AW.
  assign addr_inc     = base_q + AW'(idx_inc);

  // The tag follows the read that is on the bus during this cycle.
  assign issue_tag.valid = rd_q;
  assign issue_tag.idx   = idx_q;

  rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (Clk1),
    .rst     (Reset),
    .issue   (issue_tag),
    .capture (cap_tag)
  );

  // FSM state register.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state <= VX_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      VX_IDLE: begin
        if (Start) begin
          state_n = (Op == OP_LOAD) ? VX_LD_ISSUE : VX_ST_ISSUE;
        end
      end
      VX_LD_ISSUE: if (last_issue)   state_n = VX_LD_DRAIN;
      VX_LD_DRAIN: if (last_capture) state_n = VX_FINISH;
      VX_ST_ISSUE: if (last_issue)   state_n = VX_FINISH;
      VX_FINISH:                     state_n = VX_IDLE;
      default:                       state_n = VX_IDLE;
    endcase
  end

  // FSM output logic: next values of every registered output, so each
  // output changes on the same edge as the state it belongs to.
  always_comb begin
    idx_d  = idx_q;
    base_d = base_q;
    snap_d = snap_q;
    addr_d = addr_q;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    dout_d = dout_q;
    done_d = 1'b0;
    we_d   = 1'b0;
    busy_d = (state_n != VX_IDLE);
    case (state)
      VX_IDLE: begin
        if (Start) begin
          idx_d  = 4'd0;
          base_d = Base;
          snap_d = VecIn;
          addr_d = Base;
          rd_d   = (Op == OP_LOAD);
          wr_d   = (Op == OP_STORE);
          // Snapshot is not yet loaded, so element 0 comes straight from VecIn.
          if (Op == OP_STORE) begin
            dout_d = VecIn[DW-1:0];
          end
        end
      end
      VX_LD_ISSUE: begin
        if (!last_issue) begin
          idx_d  = idx_inc;
          addr_d = addr_inc;
          rd_d   = 1'b1;
        end
      end
      VX_LD_DRAIN: begin
        if (last_capture) begin
          done_d = 1'b1;
          we_d   = 1'b1;
        end
      end
      VX_ST_ISSUE: begin
        if (!last_issue) begin
          idx_d  = idx_inc;
          addr_d = addr_inc;
          wr_d   = 1'b1;
          dout_d = snap_q[int'(idx_inc)*DW +: DW];
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      idx_q  <= '0;
      base_q <= '0;
      snap_q <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      dout_q <= '0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      vec_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      snap_q <= snap_d;
      addr_q <= addr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
      done_q <= done_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      if (cap_tag.valid) begin
        vec_q[int'(cap_tag.idx)*DW +: DW] <= mem.MemDataIn;
      end
    end
  end

  assign mem.MemAddr    = addr_q;
  assign mem.MemRD      = rd_q;
  assign mem.MemWR      = wr_q;
  assign mem.MemDataOut = dout_q;

  assign VecOut    = vec_q;
  assign VecWE     = we_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_vec_mem_xfer.sv
`timescale 1ns/1ps
module tb_vec_mem_xfer;
  import cvp14_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT A (RD_LAT=1) ----------------
  logic         start_a, op_a, we_a, busy_a, done_a;
  logic [15:0]  base_a;
  logic [255:0] vin_a, vout_a;
  vx_state_e    dbg_a;
  vec_mem_xfer_if #(.AW(16), .DW(16)) bus_a ();

  vec_mem_xfer #(.LANES(16), .DW(16), .AW(16), .RD_LAT(1)) dut_a (
    .Clk1(clk), .Reset(rst), .Start(start_a), .Op(op_a), .Base(base_a),
    .VecIn(vin_a), .VecOut(vout_a), .VecWE(we_a), .Busy(busy_a), .Done(done_a),
    .dbg_state(dbg_a), .mem(bus_a)
  );

  // ---------------- DUT B (RD_LAT=3) ----------------
  logic         start_b, op_b, we_b, busy_b, done_b;
  logic [15:0]  base_b;
  logic [255:0] vin_b, vout_b;
  vx_state_e    dbg_b;
  vec_mem_xfer_if #(.AW(16), .DW(16)) bus_b ();

  vec_mem_xfer #(.LANES(16), .DW(16), .AW(16), .RD_LAT(3)) dut_b (
    .Clk1(clk), .Reset(rst), .Start(start_b), .Op(op_b), .Base(base_b),
    .VecIn(vin_b), .VecOut(vout_b), .VecWE(we_b), .Busy(busy_b), .Done(done_b),
    .dbg_state(dbg_b), .mem(bus_b)
  );

  // ---------------- memory model ----------------
  // Read data is presented only in the cycle it is valid; 0xDEAD otherwise.
  logic [15:0] mem [0:65535];
  logic        a_v = 1'b0;
  logic [15:0] a_d = 16'h0;
  logic [2:0]  b_v = 3'b0;
  logic [15:0] b_d0 = 16'h0, b_d1 = 16'h0, b_d2 = 16'h0;

  always @(posedge clk) begin
    a_v  <= bus_a.MemRD;
    a_d  <= mem[bus_a.MemAddr];
    b_v  <= {b_v[1:0], bus_b.MemRD};
    b_d0 <= mem[bus_b.MemAddr];
    b_d1 <= b_d0;
    b_d2 <= b_d1;
  end

  assign bus_a.MemDataIn = a_v    ? a_d  : 16'hDEAD;
  assign bus_b.MemDataIn = b_v[2] ? b_d2 : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        op;
    logic [15:0] base;
    logic [15:0] seed;      // element i = seed + step*i (mod 2^16)
    logic [15:0] step;
    int          exp_done;  // cycle of Done, counted from the Start edge
    int          exp_we;    // number of VecWE pulses
  } row_t;

  row_t rows [4];

  // One transfer on DUT A; checks bus activity per cycle and the result.
  task automatic run_row(input row_t r, input string tag);
    int           done_cnt = 0, we_cnt = 0, busy_cnt = 0, both_cnt = 0, done_cyc = -1;
    logic [255:0] v;
    logic [15:0]  e, ea;
    for (int i = 0; i < 16; i++) begin
      e  = r.seed + r.step * 16'(i);
      ea = r.base + 16'(i);
      if (r.op == OP_LOAD) mem[ea] = e;
      v[i*16 +: 16] = e;
    end
    @(negedge clk);
    start_a = 1'b1;
    op_a    = r.op;
    base_a  = r.base;
    vin_a   = (r.op == OP_STORE) ? v : 256'd0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 2) vin_a = ~vin_a;
      if (bus_a.MemRD && bus_a.MemWR) both_cnt++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (we_a)   we_cnt++;
      if (busy_a) busy_cnt++;
      if (c <= 16) begin
        ea = r.base + 16'(c - 1);
        check($sformatf("%s strobe c%0d", tag, c),
              {31'd0, (r.op == OP_LOAD) ? bus_a.MemRD : bus_a.MemWR}, 32'd1);
        check($sformatf("%s addr c%0d", tag, c), {16'd0, bus_a.MemAddr}, {16'd0, ea});
        if (r.op == OP_STORE)
          check($sformatf("%s wdata c%0d", tag, c), {16'd0, bus_a.MemDataOut},
                {16'd0, v[(c-1)*16 +: 16]});
      end else if (c == 17) begin
        check($sformatf("%s strobes off c17", tag), {30'd0, bus_a.MemRD, bus_a.MemWR}, 32'd0);
      end
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_cyc, r.exp_done);
    check({tag, " vecwe_count"}, we_cnt, r.exp_we);
    check({tag, " busy_cycles"}, busy_cnt, r.exp_done);
    check({tag, " rd_wr_overlap"}, both_cnt, 0);
    if (r.op == OP_LOAD) begin
      for (int i = 0; i < 16; i++) begin
        e = r.seed + r.step * 16'(i);
        check($sformatf("%s elem%0d", tag, i), {16'd0, vout_a[i*16 +: 16]}, {16'd0, e});
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int          done_cnt, we_cnt, done_cyc, we_cyc, wr_cnt, rd_cnt, done2_cyc, busy_cnt;
    logic [15:0] e, ea, data19;
    logic [255:0] v;

    rows[0] = '{OP_LOAD,  16'h0100, 16'hA000, 16'h0001, 18, 1};
    rows[1] = '{OP_STORE, 16'h0200, 16'h0000, 16'h1111, 17, 0};
    rows[2] = '{OP_LOAD,  16'hFFF8, 16'h5000, 16'h0101, 18, 1};
    rows[3] = '{OP_STORE, 16'hFFFC, 16'hBEEF, 16'h0F0F, 17, 0};

    rst = 1'b1;
    start_a = 1'b0; op_a = 1'b0; base_a = '0; vin_a = '0;
    start_b = 1'b0; op_b = 1'b0; base_b = '0; vin_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst busy_a",  {31'd0, busy_a}, 0);
    check("rst done_a",  {31'd0, done_a}, 0);
    check("rst we_a",    {31'd0, we_a}, 0);
    check("rst rd_wr_a", {30'd0, bus_a.MemRD, bus_a.MemWR}, 0);
    check("rst addr_a",  {16'd0, bus_a.MemAddr}, 0);
    check("rst wdata_a", {16'd0, bus_a.MemDataOut}, 0);
    check("rst vout_a",  {31'd0, |vout_a}, 0);
    check("rst state_a", {29'd0, dbg_a}, {29'd0, VX_IDLE});
    check("rst busy_b",  {31'd0, busy_b}, 0);
    check("rst vout_b",  {31'd0, |vout_b}, 0);

    // RD_LAT=3 load on DUT B.
    for (int i = 0; i < 16; i++) begin
      ea = 16'h0300 + 16'(i);
      mem[ea] = 16'hC000 + 16'(3 * i);
    end
    done_cnt = 0; we_cnt = 0; done_cyc = -1; we_cyc = -1; data19 = 16'h0;
    @(negedge clk);
    start_b = 1'b1; op_b = OP_LOAD; base_b = 16'h0300;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (c == 3 || c == 4) check($sformatf("lat3 no_capture c%0d", c), {31'd0, |vout_b}, 0);
      if (c == 5) begin
        check("lat3 elem0 c5", {16'd0, vout_b[15:0]}, 32'h0000C000);
        check("lat3 rest c5", {31'd0, |vout_b[255:16]}, 0);
      end
      if (c == 19) data19 = bus_b.MemDataIn;
      if (done_b) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (we_b) begin we_cnt++; if (we_cyc < 0) we_cyc = c; end
    end
    check("lat3 done_cycle", done_cyc, 20);
    check("lat3 vecwe_cycle", we_cyc, 20);
    check("lat3 done_count", done_cnt, 1);
    check("lat3 vecwe_count", we_cnt, 1);
    check("lat3 elem15 vs c19 data", {16'd0, vout_b[255:240]}, {16'd0, data19});
    for (int i = 0; i < 16; i++) begin
      e = 16'hC000 + 16'(3 * i);
      check($sformatf("lat3 elem%0d", i), {16'd0, vout_b[i*16 +: 16]}, {16'd0, e});
    end

    // Table-driven transfers on DUT A.
    for (int r = 0; r < 4; r++) begin
      run_row(rows[r], $sformatf("row%0d", r));
    end

    // Start during a store is ignored; Start the cycle after Done is accepted.
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h7700 + 16'(i);
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; done2_cyc = -1;
    @(negedge clk);
    start_a = 1'b1; op_a = OP_STORE; base_a = 16'h0400; vin_a = v;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (bus_a.MemWR) wr_cnt++;
      if (bus_a.MemRD) rd_cnt++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c; else done2_cyc = c;
      end
      if (c == 16) begin
        check("ign last addr",  {16'd0, bus_a.MemAddr}, 32'h0000040F);
        check("ign last wdata", {16'd0, bus_a.MemDataOut}, 32'h0000770F);
      end
      if (c == 19) begin
        check("restart busy", {31'd0, busy_a}, 1);
        check("restart rd",   {31'd0, bus_a.MemRD}, 1);
        check("restart addr", {16'd0, bus_a.MemAddr}, 32'h00000100);
      end
      if (c == 5) begin
        start_a = 1'b1; op_a = OP_LOAD; base_a = 16'h0500;
      end
      if (c == 18) begin
        start_a = 1'b1; op_a = OP_LOAD; base_a = 16'h0100;
      end
    end
    check("ign write_count", wr_cnt, 16);
    check("ign read_count", rd_cnt, 16);
    check("ign done_count", done_cnt, 2);
    check("ign done_cycle", done_cyc, 17);
    check("restart done_cycle", done2_cyc, 36);

    // Reset in cycle 8 of a load aborts it.
    done_cnt = 0; we_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    start_a = 1'b1; op_a = OP_LOAD; base_a = 16'hFFF8;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 8) begin
        check("abort busy c8", {31'd0, busy_a}, 1);
        check("abort rd c8",   {31'd0, bus_a.MemRD}, 1);
        rst = 1'b1;
      end
      if (c == 9) begin
        rst = 1'b0;
        check("abort rd c9",    {31'd0, bus_a.MemRD}, 0);
        check("abort busy c9",  {31'd0, busy_a}, 0);
        check("abort vout c9",  {31'd0, |vout_a}, 0);
        check("abort state c9", {29'd0, dbg_a}, {29'd0, VX_IDLE});
      end
      if (c > 9) begin
        if (done_a) done_cnt++;
        if (we_a)   we_cnt++;
        if (busy_a) busy_cnt++;
      end
    end
    check("abort done_count", done_cnt, 0);
    check("abort vecwe_count", we_cnt, 0);
    check("abort busy_after", busy_cnt, 0);
    check("abort vout_end", {31'd0, |vout_a}, 0);

    // Start together with Reset is discarded.
    @(negedge clk);
    rst = 1'b1; start_a = 1'b1; op_a = OP_LOAD; base_a = 16'h0100;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    check("rst+start busy", {31'd0, busy_a}, 0);
    check("rst+start rd",   {31'd0, bus_a.MemRD}, 0);
    @(negedge clk);
    check("rst+start busy later", {31'd0, busy_a}, 0);

    // A normal load after the abort.
    run_row(rows[0], "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
